// File: rtl/bp_be_pkg.sv
// Shared types and helpers for the backend cache-request arbiter.
package bp_be_pkg;

  typedef enum logic [1:0] {
    e_idle = 2'd0,
    e_meta = 2'd1,
    e_busy = 2'd2
  } bp_be_cache_req_arb_state_e;

  localparam int unsigned bp_be_num_req_lp = 2;

  function automatic logic [bp_be_num_req_lp-1:0] bp_be_onehot2(input logic idx);
    bp_be_onehot2 = idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/bp_be_cache_req_arbiter_if.sv
// Requester-side and LCE-side signal bundle of the cache-request arbiter.
interface bp_be_cache_req_arbiter_if #(
  parameter int unsigned req_width_p  = 128,
  parameter int unsigned meta_width_p = 8
);
  logic [1:0][req_width_p-1:0]  req_i;
  logic [1:0]                   req_v_i;
  logic [1:0]                   req_ready_o;
  logic [1:0][meta_width_p-1:0] meta_i;
  logic [1:0]                   meta_v_i;

  logic [req_width_p-1:0]       cache_req_o;
  logic                         cache_req_v_o;
  logic                         cache_req_ready_i;
  logic [meta_width_p-1:0]      cache_req_metadata_o;
  logic                         cache_req_metadata_v_o;
  logic                         cache_req_complete_i;

  logic [1:0]                   complete_o;
  logic                         owner_o;
  logic                         busy_o;

  // master: the arbiter itself; slave: requesters plus LCE
  modport master (
    input  req_i, req_v_i, meta_i, meta_v_i, cache_req_ready_i, cache_req_complete_i,
    output req_ready_o, cache_req_o, cache_req_v_o, cache_req_metadata_o,
           cache_req_metadata_v_o, complete_o, owner_o, busy_o
  );

  modport slave (
    output req_i, req_v_i, meta_i, meta_v_i, cache_req_ready_i, cache_req_complete_i,
    input  req_ready_o, cache_req_o, cache_req_v_o, cache_req_metadata_o,
           cache_req_metadata_v_o, complete_o, owner_o, busy_o
  );
endinterface

// File: rtl/bp_be_cache_req_arbiter_rr_arb_2.sv
// Two-input round-robin pick: sole valid requester wins, ties go to prio_i.
module bp_be_rr_arb_2 (
  input  logic [1:0] v_i,
  input  logic       prio_i,
  output logic       grant_o
);

  always_comb begin
    case (v_i)
      2'b11:   grant_o = prio_i;
      2'b10:   grant_o = 1'b1;
      default: grant_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/bp_be_cache_req_arbiter.sv
// Arbitrates the D$ and page-table walker onto one LCE request channel,
// holding a single transaction from grant through metadata to completion.
module bp_be_cache_req_arbiter
  import bp_be_pkg::*;
#(
  parameter int unsigned req_width_p  = 128,
  parameter int unsigned meta_width_p = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  bp_be_cache_req_arbiter_if.master bus
);

  bp_be_cache_req_arb_state_e state_r, state_n;
  logic owner_r, owner_n;
  logic prio_r, prio_n;
  logic pend_r, pend_n;
  logic [1:0] complete_r, complete_n;
  logic winner;
  logic done;

  logic                    cache_req_v;
  logic [req_width_p-1:0]  cache_req;
  logic [1:0]              req_ready;
  logic                    meta_v;
  logic [meta_width_p-1:0] meta;

  bp_be_rr_arb_2 rr_arb (
    .v_i    (bus.req_v_i),
    .prio_i (prio_r),
    .grant_o(winner)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r    <= e_idle;
      owner_r    <= 1'b0;
      prio_r     <= 1'b0;
      pend_r     <= 1'b0;
      complete_r <= '0;
    end else begin
      state_r    <= state_n;
      owner_r    <= owner_n;
      prio_r     <= prio_n;
      pend_r     <= pend_n;
      complete_r <= complete_n;
    end
  end

  always_comb begin
    state_n     = state_r;
    owner_n     = owner_r;
    prio_n      = prio_r;
    pend_n      = pend_r;
    complete_n  = '0;
    done        = 1'b0;
    cache_req_v = 1'b0;
    cache_req   = '0;
    req_ready   = '0;
    meta_v      = 1'b0;
    meta        = '0;

    case (state_r)
      e_idle: begin
        pend_n           = 1'b0;
        cache_req_v      = bus.req_v_i[winner];
        cache_req        = bus.req_i[winner];
        req_ready[winner] = bus.cache_req_ready_i;
        if (cache_req_v && bus.cache_req_ready_i) begin
          owner_n = winner;
          state_n = e_meta;
        end
      end
      e_meta: begin
        meta_v = bus.meta_v_i[owner_r];
        meta   = bus.meta_i[owner_r];
        if (meta_v) begin
          pend_n = 1'b0;
          // A completion seen before or with the metadata closes the transaction now
          if (bus.cache_req_complete_i || pend_r) begin
            done    = 1'b1;
            state_n = e_idle;
          end else begin
            state_n = e_busy;
          end
        end else if (bus.cache_req_complete_i) begin
          pend_n = 1'b1;
        end
      end
      e_busy: begin
        if (bus.cache_req_complete_i) begin
          done    = 1'b1;
          state_n = e_idle;
        end
      end
      default: state_n = e_idle;
    endcase

    if (done) begin
      complete_n = bp_be_onehot2(owner_r);
      prio_n     = ~owner_r;
    end
  end

  // Combinational paths are gated so every output reads zero while reset is held
  assign bus.cache_req_v_o          = cache_req_v & ~reset_i;
  assign bus.cache_req_o            = reset_i ? '0 : cache_req;
  assign bus.req_ready_o            = reset_i ? '0 : req_ready;
  assign bus.cache_req_metadata_v_o = meta_v & ~reset_i;
  assign bus.cache_req_metadata_o   = reset_i ? '0 : meta;
  assign bus.complete_o             = complete_r;
  assign bus.owner_o                = owner_r;
  assign bus.busy_o                 = (state_r != e_idle);

endmodule

// File: doc/bp_be_cache_req_arbiter.md
BP_BE_CACHE_REQ_ARBITER -- requirements
Module: bp_be_cache_req_arbiter

Interface
REQ-001 SHALL have parameter req_width_p, default 128, width of one cache request packet.
REQ-002 SHALL have parameter meta_width_p, default 8, width of one cache request metadata packet.
REQ-003 SHALL have port clk_i  input  1  the single clock.
REQ-004 SHALL have port reset_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports req_i[0..1]  input  req_width_p each  requester packets; index 0 is the D$, index 1 is the page-table walker.
REQ-006 SHALL have ports req_v_i[1:0] (input, 2) for requester valid and req_ready_o[1:0] (output, 2) for requester ready.
REQ-007 SHALL have ports meta_i[0..1] (input, meta_width_p each) and meta_v_i[1:0] (input, 2) for requester metadata.
REQ-008 SHALL have ports cache_req_o (output, req_width_p), cache_req_v_o (output, 1) and cache_req_ready_i (input, 1) toward the LCE.
REQ-009 SHALL have ports cache_req_metadata_o (output, meta_width_p) and cache_req_metadata_v_o (output, 1) toward the LCE.
REQ-010 SHALL have ports cache_req_complete_i (input, 1) from the LCE and complete_o[1:0] (output, 2), a per-requester completion pulse.
REQ-011 SHALL have port owner_o  output  1  index of the requester that currently owns the channel; the value is valid when busy_o=1.
REQ-012 SHALL have port busy_o  output  1  high in every state except e_idle.

Function
REQ-013 SHALL implement FSM states e_idle, e_meta and e_busy.
REQ-014 In e_idle, the winner SHALL be the sole valid requester; if both requesters are valid, the winner SHALL be the one selected by the priority bit prio_r.
REQ-015 In e_idle, the block SHALL drive cache_req_v_o = req_v_i[winner] and cache_req_o = req_i[winner] combinationally.
REQ-016 In e_idle, the block SHALL drive req_ready_o[winner] = cache_req_ready_i and req_ready_o[loser] = 0.
REQ-017 On the handshake (cache_req_v_o & cache_req_ready_i), the block SHALL latch owner_r = winner and go to e_meta.
REQ-018 Outside e_idle, the block SHALL hold cache_req_v_o and both req_ready_o bits at 0.
REQ-019 In e_meta, the block SHALL forward meta_i[owner_r] and meta_v_i[owner_r] combinationally to cache_req_metadata_o and cache_req_metadata_v_o.
REQ-020 In e_meta, meta_v_i of the non-owner SHALL be ignored.
REQ-021 The FSM SHALL leave e_meta on the first cycle in which meta_v_i[owner_r]=1, going to e_busy.
REQ-022 If cache_req_complete_i=1 in the same cycle as meta_v_i[owner_r]=1 in e_meta, the FSM SHALL go directly to e_idle and complete that transaction.
REQ-023 If cache_req_complete_i=1 in e_meta without meta_v_i[owner_r], the block SHALL latch a pending-complete flag; the metadata-accept cycle SHALL then complete the transaction and return the FSM to e_idle.
REQ-024 In e_busy, cache_req_complete_i=1 SHALL move the FSM to e_idle.
REQ-025 Completion of a transaction SHALL assert complete_o[owner_r] for exactly one cycle, the cycle after the completing event (registered), and SHALL set prio_r to ~owner_r.
REQ-026 In e_idle, cache_req_complete_i SHALL be ignored, and no complete_o SHALL be generated.
REQ-027 Latency: a request accepted in cycle N SHALL have its metadata forwarded no earlier than N+1; after completion in cycle M, a new grant SHALL be possible in cycle M+1.
REQ-028 The block SHALL allow at most one outstanding transaction.
REQ-029 A requester whose req_v_i drops before the handshake SHALL lose no state: arbitration SHALL be re-evaluated every cycle in e_idle, and prio_r SHALL NOT change.

Reset
REQ-030 Asserting reset_i, including mid-transaction, SHALL force the FSM to e_idle, prio_r=0, owner_r=0 and clear the pending-complete flag.
REQ-031 While reset_i is high, all outputs SHALL be 0 (cache_req_v_o, req_ready_o, cache_req_metadata_v_o, complete_o, busy_o, owner_o); cache_req_o and cache_req_metadata_o SHALL be 0.
REQ-032 After reset deassertion, an in-flight LCE completion SHALL NOT produce complete_o.

Structure
REQ-033 The FSM state enum (bp_be_cache_req_arb_state_e) SHALL reside in bp_be_pkg.
REQ-034 The priority select SHALL be a sub-module bp_be_rr_arb_2 (two-input round-robin pick given prio_r); everything else SHALL be flat.

Verification
REQ-035 Single requester: req_v_i=2'b01, ready=1 in cycle 0; meta_v_i[0] in cycle 2; complete in cycle 5 -> grant in cycle 0, metadata forwarded in cycle 2, complete_o=2'b01 in cycle 6, busy_o low in cycle 6.
REQ-036 Contention: both requesters held valid after reset -> grants alternate 0,1,0,1 across four transactions, and the loser's req_ready_o stays 0.
REQ-037 Back-pressure: cache_req_ready_i=0 for 3 cycles with req_v_i[1]=1 -> no handshake and the FSM stays in e_idle; when ready rises the grant goes to owner 1.
REQ-038 Early complete: cache_req_complete_i in e_meta one cycle before meta_v_i -> metadata still forwarded, the FSM returns to e_idle, and exactly one complete_o pulse is generated.
REQ-039 Non-owner metadata: meta_v_i[1]=1 while owner=0 in e_meta -> cache_req_metadata_v_o stays 0.
REQ-040 Mid-operation reset: reset_i asserted in e_busy -> busy_o=0 immediately; a later cache_req_complete_i yields no complete_o, and the next grant goes to requester 0.
